ls_ctrl_sig_master: RTL and testbench
=====================================

Name: ls_ctrl_sig_master

Overview:
Avalon-MM initiator that drives the 4-bit low-speed control-signal PIO slave and any other 2-bit-address register slave on the same bus.
- Accepts single read/write commands from local control logic through a valid/ready interface.
- Runs each command as one Avalon-MM transfer, honouring waitrequest and a fixed read latency.
- Returns read data or write completion, with an error flag on timeout.
- Sits between the run-control FSM and the PIO slave's s1 port.

Parameters:
ADDR_W, 2, Avalon address width.
DATA_W, 32, Avalon data width.
READ_LATENCY, 0, cycles from accepted read to valid readdata (0..3).
TIMEOUT, 255, max cycles waitrequest may stay high before abort (1..65535).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_address  in  ADDR_W  target register
cmd_writedata  in  DATA_W  write payload
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_readdata  out  DATA_W  read result; 0 for writes and on error
rsp_error  out  1  transfer timed out
avm_address  out  ADDR_W  bus address
avm_chipselect  out  1  bus select
avm_write_n  out  1  active-low write strobe
avm_read  out  1  read strobe
avm_writedata  out  DATA_W  bus write data
avm_readdata  in  DATA_W  bus read data
avm_waitrequest  in  1  slave stall; tie 0 for zero-wait slaves

Behaviour:
Reset values (async, immediate on reset=1):
- cmd_ready=0, rsp_valid=0, rsp_readdata=0, rsp_error=0
- avm_chipselect=0, avm_write_n=1, avm_read=0, avm_address=0, avm_writedata=0
- state=IDLE, timeout counter=0, latency counter=0
- Any in-flight transfer is abandoned, with no response. The first cycle after reset deasserts is IDLE.

State machine:
- IDLE: cmd_ready=1. On cmd_valid, register address, data and direction, then go to XFER. cmd_ready is 0 in every other state, so there is one outstanding command.
- XFER: drive chipselect=1 plus write_n=0 (write) or read=1 (read), with registered address and data. All bus outputs come from registers, with no combinational path from cmd_* to avm_*.
  - If waitrequest=0: the transfer is accepted this cycle. A write goes to RESP. A read goes to RESP when READ_LATENCY=0, sampling avm_readdata this cycle; otherwise it goes to RDWAIT.
  - If waitrequest=1: hold all bus outputs stable and increment the timeout counter. When the counter reaches TIMEOUT, deassert the strobes, set rsp_error=1 and rsp_readdata=0, then go to RESP.
- RDWAIT: strobes and chipselect deasserted. Count READ_LATENCY cycles after acceptance, sample avm_readdata on the final one, then go to RESP.
- RESP: rsp_valid=1 with stable data and error. On rsp_ready, clear rsp_valid, clear the error and counters, then go to IDLE.

Timing and boundary rules:
- Zero-wait write: command accepted at cycle N, strobe at N+1, rsp_valid at N+2. Minimum issue interval is 3 cycles.
- Zero-wait read with READ_LATENCY=0: the same schedule as a write.
- Strobes are asserted for exactly one cycle per accepted transfer, or for 1+k cycles under k wait states.
- At most one strobe is active at a time. avm_write_n and avm_read are never both active.
- The timeout counter is 16 bits and saturating, cleared on entry to XFER. A TIMEOUT value above 65535 is out of range.
- A command presented while busy is held off by cmd_ready=0 and must not be lost. It is accepted on the next IDLE cycle.
- rsp_ready held high permanently gives single-cycle responses. Backpressure on rsp_ready stalls the block indefinitely with rsp_* stable.
- Reset asserted during XFER drops the bus strobes asynchronously in the same cycle.

Test Plan:
- Write addr 0 data 0x0000_000A, waitrequest=0 -> one cycle with chipselect=1, write_n=0, address=0, writedata=0xA; rsp_valid 2 cycles after acceptance; rsp_error=0; PIO slave out_port=4'hA.
- Read addr 0 after that write, READ_LATENCY=0 -> read strobe for 1 cycle; rsp_readdata=0x0000_000A; read of addr 1 returns 0x0.
- Write with waitrequest held high for 5 cycles -> strobe and address/data stable for 6 cycles; a single write seen by the slave; rsp_error=0.
- TIMEOUT=8, waitrequest stuck high -> strobe for 8 cycles then released; rsp_error=1, rsp_readdata=0; next command runs normally.
- Back-to-back commands with cmd_valid always high and rsp_ready held low for 10 cycles -> cmd_ready=0 throughout; rsp_valid stable; second transfer starts only after the response handshake.
- reset pulsed while the read strobe is high -> chipselect=0 and read=0 immediately; no rsp_valid; the next command completes correctly.

Source files
------------

// File: rtl/ls_ctrl_sig_master.sv
// Avalon-MM initiator: runs one local valid/ready command per bus transfer and
// returns read data or write completion, flagging waitrequest timeouts.
module ls_ctrl_sig_master #(
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_address_i,
    input  logic [DATA_W-1:0] cmd_writedata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_readdata_o,
    output logic              rsp_error_o,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic              avm_chipselect_o,
    output logic              avm_write_n_o,
    output logic              avm_read_o,
    output logic [DATA_W-1:0] avm_writedata_o,
    input  logic [DATA_W-1:0] avm_readdata_i,
    input  logic              avm_waitrequest_i
);

    typedef enum logic [1:0] {IDLE, XFER, RDWAIT, RESP} state_t;

    // Abort fires on the stalled cycle that would bring the counter to TIMEOUT.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [1:0]  LAT_LAST = 2'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_readdata_q, rsp_readdata_d;
    logic                rsp_error_q, rsp_error_d;
    logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
    logic                avm_chipselect_q, avm_chipselect_d;
    logic                avm_write_n_q, avm_write_n_d;
    logic                avm_read_q, avm_read_d;
    logic [DATA_W-1:0]   avm_writedata_q, avm_writedata_d;
    logic [15:0]         tmo_q, tmo_d;
    logic [1:0]          lat_q, lat_d;

    // State and output registers; reset drops the bus strobes immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= IDLE;
            cmd_ready_q      <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_readdata_q   <= '0;
            rsp_error_q      <= 1'b0;
            avm_address_q    <= '0;
            avm_chipselect_q <= 1'b0;
            avm_write_n_q    <= 1'b1;
            avm_read_q       <= 1'b0;
            avm_writedata_q  <= '0;
            tmo_q            <= 16'd0;
            lat_q            <= 2'd0;
        end else begin
            state_q          <= state_d;
            cmd_ready_q      <= cmd_ready_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_readdata_q   <= rsp_readdata_d;
            rsp_error_q      <= rsp_error_d;
            avm_address_q    <= avm_address_d;
            avm_chipselect_q <= avm_chipselect_d;
            avm_write_n_q    <= avm_write_n_d;
            avm_read_q       <= avm_read_d;
            avm_writedata_q  <= avm_writedata_d;
            tmo_q            <= tmo_d;
            lat_q            <= lat_d;
        end
    end

    // Next-state and next-output logic for the single-outstanding transfer.
    always_comb begin
        state_d          = state_q;
        cmd_ready_d      = cmd_ready_q;
        rsp_valid_d      = rsp_valid_q;
        rsp_readdata_d   = rsp_readdata_q;
        rsp_error_d      = rsp_error_q;
        avm_address_d    = avm_address_q;
        avm_chipselect_d = avm_chipselect_q;
        avm_write_n_d    = avm_write_n_q;
        avm_read_d       = avm_read_q;
        avm_writedata_d  = avm_writedata_q;
        tmo_d            = tmo_q;
        lat_d            = lat_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d      = 1'b0;
                    avm_address_d    = cmd_address_i;
                    avm_writedata_d  = cmd_writedata_i;
                    avm_chipselect_d = 1'b1;
                    avm_write_n_d    = ~cmd_write_i;
                    avm_read_d       = ~cmd_write_i;
                    tmo_d            = 16'd0;
                    state_d          = XFER;
                end else begin
                    cmd_ready_d      = 1'b1;
                end
            end
            XFER: begin
                tmo_d = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
                if (!avm_waitrequest_i) begin
                    avm_chipselect_d = 1'b0;
                    avm_write_n_d    = 1'b1;
                    avm_read_d       = 1'b0;
                    lat_d            = 2'd0;
                    rsp_error_d      = 1'b0;
                    if (!avm_read_q) begin
                        rsp_readdata_d = '0;
                        rsp_valid_d    = 1'b1;
                        state_d        = RESP;
                    end else if (READ_LATENCY == 0) begin
                        rsp_readdata_d = avm_readdata_i;
                        rsp_valid_d    = 1'b1;
                        state_d        = RESP;
                    end else begin
                        state_d        = RDWAIT;
                    end
                end else if (tmo_q >= TMO_LAST) begin
                    avm_chipselect_d = 1'b0;
                    avm_write_n_d    = 1'b1;
                    avm_read_d       = 1'b0;
                    rsp_error_d      = 1'b1;
                    rsp_readdata_d   = '0;
                    rsp_valid_d      = 1'b1;
                    state_d          = RESP;
                end else begin
                    state_d          = XFER;
                end
            end
            RDWAIT: begin
                if (lat_q == LAT_LAST) begin
                    rsp_readdata_d = avm_readdata_i;
                    rsp_error_d    = 1'b0;
                    rsp_valid_d    = 1'b1;
                    state_d        = RESP;
                end else begin
                    lat_d          = lat_q + 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d    = 1'b0;
                    rsp_error_d    = 1'b0;
                    rsp_readdata_d = '0;
                    tmo_d          = 16'd0;
                    lat_d          = 2'd0;
                    cmd_ready_d    = 1'b1;
                    state_d        = IDLE;
                end else begin
                    state_d        = RESP;
                end
            end
            default: begin
                avm_chipselect_d = 1'b0;
                avm_write_n_d    = 1'b1;
                avm_read_d       = 1'b0;
                rsp_valid_d      = 1'b0;
                cmd_ready_d      = 1'b0;
                state_d          = IDLE;
            end
        endcase
    end

    assign cmd_ready_o      = cmd_ready_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_readdata_o   = rsp_readdata_q;
    assign rsp_error_o      = rsp_error_q;
    assign avm_address_o    = avm_address_q;
    assign avm_chipselect_o = avm_chipselect_q;
    assign avm_write_n_o    = avm_write_n_q;
    assign avm_read_o       = avm_read_q;
    assign avm_writedata_o  = avm_writedata_q;

endmodule

// File: tb/tb_ls_ctrl_sig_master.sv
// Bench for ls_ctrl_sig_master: directed vector table, hand-written corner
// sequences and random commands against a PIO-like slave and a reference model.
module tb_ls_ctrl_sig_master;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_address;
    logic [31:0] cmd_writedata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_readdata;
    logic [1:0]  avm_address;
    logic        avm_chipselect, avm_write_n, avm_read, avm_waitrequest;
    logic [31:0] avm_writedata, avm_readdata;

    int n_checks = 0;
    int n_fail   = 0;

    // slave side: out_port register at address 0, waitrequest generator
    logic [3:0] slave_reg = 4'h0;
    int         wr_seen   = 0;
    int         ws_cnt    = 0;
    int         n_wait    = 0;
    logic [3:0] model_reg = 4'h0;

    ls_ctrl_sig_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(0), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_address_i(cmd_address), .cmd_writedata_i(cmd_writedata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_readdata_o(rsp_readdata), .rsp_error_o(rsp_error),
        .avm_address_o(avm_address), .avm_chipselect_o(avm_chipselect),
        .avm_write_n_o(avm_write_n), .avm_read_o(avm_read),
        .avm_writedata_o(avm_writedata), .avm_readdata_i(avm_readdata),
        .avm_waitrequest_i(avm_waitrequest)
    );

    always #5 clk = ~clk;

    assign avm_waitrequest = avm_chipselect && (ws_cnt < n_wait);
    assign avm_readdata = (avm_chipselect && avm_read)
                        ? ((avm_address == 2'd0) ? {28'h0, slave_reg} : 32'h0)
                        : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (avm_chipselect && avm_waitrequest) ws_cnt <= ws_cnt + 1;
        else                                   ws_cnt <= 0;
        if (avm_chipselect && !avm_write_n && !avm_waitrequest) begin
            wr_seen <= wr_seen + 1;
            if (avm_address == 2'd0) slave_reg <= avm_writedata[3:0];
        end
    end

    typedef struct {
        logic        write;
        logic [1:0]  addr;
        logic [31:0] data;
        int          nwait;
        int          rsp_delay;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_strobes;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: every stalled cycle counts toward the timeout; abort after TMO strobe cycles.
    function automatic vec_t model(input logic w, input logic [1:0] a, input logic [31:0] d,
                                   input int nw, input int rd);
        vec_t v;
        v.write = w; v.addr = a; v.data = d; v.nwait = nw; v.rsp_delay = rd;
        v.exp_err     = (nw >= TMO);
        v.exp_strobes = v.exp_err ? TMO : nw + 1;
        v.exp_data    = (w || v.exp_err) ? 32'h0 : ((a == 2'd0) ? {28'h0, model_reg} : 32'h0);
        return v;
    endfunction

    // Entered and left just after a falling edge.
    task automatic run_cmd(input vec_t v);
        int   k, strobes, wr_before;
        logic bad;
        logic [31:0] held;
        n_wait = v.nwait;
        wr_before = wr_seen;
        cmd_valid = 1'b1; cmd_write = v.write; cmd_address = v.addr; cmd_writedata = v.data;
        k = 0;
        while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) check("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
        strobes = 0; bad = 1'b0; k = 1;
        while (!rsp_valid && k < 300) begin
            if (!avm_write_n && avm_read) bad = 1'b1;
            if (avm_chipselect) begin
                strobes++;
                if (avm_address !== v.addr || avm_write_n !== !v.write || avm_read !== !v.write) bad = 1'b1;
                if (v.write && avm_writedata !== v.data) bad = 1'b1;
            end
            @(negedge clk); k++;
        end
        check("bus_hold", {31'h0, bad}, 32'h0);
        check("rsp_latency", k, v.exp_strobes + 1);
        check("strobe_cycles", strobes, v.exp_strobes);
        check("rsp_readdata", rsp_readdata, v.exp_data);
        check("rsp_error", {31'h0, rsp_error}, {31'h0, v.exp_err});
        check("slave_writes", wr_seen - wr_before, (v.write && !v.exp_err) ? 1 : 0);
        bad = 1'b0; held = rsp_readdata;
        repeat (v.rsp_delay) begin
            @(negedge clk);
            if (!rsp_valid || cmd_ready || avm_chipselect || rsp_readdata !== held) bad = 1'b1;
        end
        if (v.rsp_delay > 0) check("rsp_backpressure", {31'h0, bad}, 32'h0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", {30'h0, rsp_valid, cmd_ready}, 32'h1);
        if (v.write && !v.exp_err && v.addr == 2'd0) model_reg = v.data[3:0];
    endtask

    initial begin
        int   k;
        logic bad;
        vec_t v;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 2'd0;
        cmd_writedata = 32'h0; rsp_ready = 1'b0;

        tbl[0] = '{1'b1, 2'd0, 32'h0000_000A, 0,   0, 32'h0, 1'b0, 1};
        tbl[1] = '{1'b0, 2'd0, 32'h0,         0,   0, 32'hA, 1'b0, 1};
        tbl[2] = '{1'b0, 2'd1, 32'h0,         0,   0, 32'h0, 1'b0, 1};
        tbl[3] = '{1'b1, 2'd0, 32'h0000_0005, 5,   0, 32'h0, 1'b0, 6};
        tbl[4] = '{1'b0, 2'd0, 32'h0,         2,   0, 32'h5, 1'b0, 3};
        tbl[5] = '{1'b1, 2'd0, 32'h0000_000C, 255, 0, 32'h0, 1'b1, 8};
        tbl[6] = '{1'b0, 2'd0, 32'h0,         0,   0, 32'h5, 1'b0, 1};
        tbl[7] = '{1'b0, 2'd2, 32'h0,         255, 0, 32'h0, 1'b1, 8};
        tbl[8] = '{1'b1, 2'd3, 32'h1234_5678, 7,   2, 32'h0, 1'b0, 8};
        tbl[9] = '{1'b0, 2'd0, 32'h0,         0,   4, 32'h5, 1'b0, 1};

        #2;
        check("rst_rsp", {rsp_readdata[29:0], rsp_valid, rsp_error}, 32'h0);
        check("rst_handshake", {31'h0, cmd_ready}, 32'h0);
        check("rst_bus", {avm_writedata[27:0], avm_address, avm_chipselect, avm_read}, 32'h0);
        check("rst_write_n", {31'h0, avm_write_n}, 32'h1);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        check("rst_first_idle", {31'h0, cmd_ready}, 32'h0);
        @(negedge clk);
        check("ready_after_rst", {31'h0, cmd_ready}, 32'h1);

        for (int i = 0; i < 10; i++) run_cmd(tbl[i]);

        // back-to-back: second command held while the first response is stalled
        n_wait = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd0; cmd_writedata = 32'h3;
        @(negedge clk);
        cmd_write = 1'b0; cmd_writedata = 32'h0;
        k = 0;
        while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
        bad = 1'b0;
        repeat (10) begin
            if (cmd_ready || !rsp_valid || rsp_error || avm_chipselect) bad = 1'b1;
            @(negedge clk);
        end
        check("b2b_holdoff", {31'h0, bad}, 32'h0);
        check("b2b_first_write", {28'h0, slave_reg}, 32'h3);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);
        check("b2b_second_strobe", {30'h0, avm_chipselect, avm_read}, 32'h3);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_data", rsp_readdata, 32'h3);
        check("b2b_second_valid", {31'h0, rsp_valid}, 32'h1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        model_reg = 4'h3;

        // reset pulsed while the read strobe is high
        n_wait = 3;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_strobe", {30'h0, avm_chipselect, avm_read}, 32'h3);
        reset = 1'b1;
        #1;
        check("rst_drops_strobe", {30'h0, avm_chipselect, avm_read}, 32'h0);
        @(negedge clk);
        reset = 1'b0; n_wait = 0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) bad = 1'b1;
        end
        check("no_rsp_after_rst", {31'h0, bad}, 32'h0);
        v = model(1'b0, 2'd0, 32'h0, 0, 0);
        run_cmd(v);

        for (int i = 0; i < 20; i++) begin
            v = model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                      $urandom_range(0, 9), $urandom_range(0, 3));
            run_cmd(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
